// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequenced one-hot decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts 0..limit-1 while enabled and pulses tc_c on the last count.
module dwell_counter #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic [DWELL_W-1:0] limit,
  output logic               tc_c
);

  logic [DWELL_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    tc_c    = en && !clear && (count_q == limit - DWELL_W'(1));
    if (clear)     count_d = '0;
    else if (tc_c) count_d = '0;
    else if (en)   count_d = count_q + DWELL_W'(1);
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered W-to-2**W one-hot decoder with load handshake; optional SCAN mode
// (walking one-hot with programmable dwell) built only when DECODER_SCAN_EN is defined.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter  int unsigned W       = 3,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned N_OUT   = 2**W
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               En,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [W-1:0]       w,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   y,
  output logic               y_valid,
  output logic [W-1:0]       sel_q,
  output logic               wrap
);

  state_e             state_q, state_d;
  logic [W-1:0]       sel_d;
  logic [N_OUT-1:0]   y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic               accept;

  assign load_ready = En;
  assign accept     = load_valid && En;
  assign y          = y_q;
  assign y_valid    = y_valid_q;

`ifdef DECODER_SCAN_EN
  logic [DWELL_W-1:0] dwell_lim_q, dwell_lim_d;
  logic               wrap_q, wrap_d;
  logic               tc_c;
  logic               cnt_clear;

  // Counter only runs while scanning; any load or disable restarts it from 0.
  assign cnt_clear = !En || accept || (state_q != SCAN);
  assign wrap      = wrap_q;

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk   (Clock),
    .rst_n (Resetn),
    .clear (cnt_clear),
    .en    (state_q == SCAN),
    .limit (dwell_lim_q),
    .tc_c  (tc_c)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dwell_lim_q <= DWELL_W'(1);
      wrap_q      <= 1'b0;
    end else begin
      dwell_lim_q <= dwell_lim_d;
      wrap_q      <= wrap_d;
    end
  end
`else
  logic unused_c;
  assign unused_c = ^{mode, dwell};
  assign wrap     = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  // Next state: disable wins, then an accepted load, then the scan step.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
`ifdef DECODER_SCAN_EN
    dwell_lim_d = dwell_lim_q;
    wrap_d      = 1'b0;
`endif
    if (!En) begin
      state_d   = IDLE;
      y_d       = '0;
      y_valid_d = 1'b0;
    end else if (accept) begin
      state_d   = HOLD;
      sel_d     = w;
      y_d       = N_OUT'(1) << w;
      y_valid_d = 1'b1;
`ifdef DECODER_SCAN_EN
      if (mode == MODE_SCAN) begin
        state_d     = SCAN;
        dwell_lim_d = (dwell == '0) ? DWELL_W'(1) : dwell;
      end
`endif
    end
`ifdef DECODER_SCAN_EN
    else if (state_q == SCAN && tc_c) begin
      sel_d  = sel_q + W'(1);
      y_d    = N_OUT'(1) << sel_d;
      wrap_d = (sel_q == W'(N_OUT - 1));
    end
`endif
  end

endmodule
